// File: rtl/tcdm_burst_reader_pkg.sv
// Shared state encoding, constants and address helper for the TCDM burst reader.
package tcdm_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [3:0]  BE_ALL     = 4'hF;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/tcdm_burst_fifo.sv
// Synchronous non-fall-through FIFO: a pushed word appears on o_dat the cycle after the push.
// No overflow guard inside; the caller only pushes words it holds a credit for.
module tcdm_burst_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_dat,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_dat,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty
);

    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;

    assign w_do_pop = i_pop && (r_count != '0);
    assign o_dat    = r_mem[r_rptr];
    assign o_count  = r_count;
    assign o_empty  = (r_count == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + PW'(1);
            end
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; only words behind the count are ever presented.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_dat;
        end
    end

endmodule

// File: rtl/tcdm_burst_reader.sv
// Reads len_i contiguous words over TCDM and streams them in order; first grant 1 cycle after start,
// data 2 cycles after grant. Requests are throttled so in-flight plus buffered words never exceed FIFO_DEPTH.
module tcdm_burst_reader
    import tcdm_burst_reader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [31:0]          base_addr_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 tcdm_req_o,
    output logic [31:0]          tcdm_add_o,
    output logic                 tcdm_wen_o,
    output logic [31:0]          tcdm_wdata_o,
    output logic [3:0]           tcdm_be_o,
    input  logic                 tcdm_gnt_i,
    input  logic                 tcdm_r_valid_i,
    input  logic [31:0]          tcdm_r_rdata_i,
    input  logic                 tcdm_r_opc_i,
    output logic [31:0]          data_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    state_t               r_state;
    logic [31:0]          r_addr;
    logic [LEN_WIDTH-1:0] r_remaining;
    logic [CW-1:0]        r_outstanding;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    logic [CW-1:0]        w_fifo_count;
    logic                 w_fifo_empty;
    logic [CW:0]          w_credits;
    logic                 w_req;
    logic                 w_gnt;
    logic                 w_pop;

    // Credits only shrink while a request waits, so an asserted request is never withdrawn.
    assign w_credits = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign w_req     = (r_state == ST_REQ) && (r_remaining != '0) && (w_credits < DEPTH_C);
    assign w_gnt     = w_req && tcdm_gnt_i;
    assign w_pop     = !w_fifo_empty && ready_i;

    assign tcdm_req_o   = w_req;
    assign tcdm_add_o   = r_addr;
    assign tcdm_wen_o   = 1'b1;
    assign tcdm_wdata_o = '0;
    assign tcdm_be_o    = BE_ALL;

    assign busy_o  = r_busy;
    assign done_o  = r_done;
    assign err_o   = r_err;
    assign valid_o = !w_fifo_empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_remaining   <= '0;
            r_outstanding <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (tcdm_r_valid_i && tcdm_r_opc_i) begin
                r_err <= 1'b1;
            end

            case ({w_gnt, tcdm_r_valid_i})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            unique case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_err <= 1'b0;
                        if (len_i != '0) begin
                            r_addr      <= word_align(base_addr_i);
                            r_remaining <= len_i;
                            r_busy      <= 1'b1;
                            r_state     <= ST_REQ;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_REQ: begin
                    if (w_gnt) begin
                        r_addr      <= r_addr + 32'(WORD_BYTES);
                        r_remaining <= r_remaining - LEN_WIDTH'(1);
                        if (r_remaining == LEN_WIDTH'(1)) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((r_outstanding == '0) && w_fifo_empty) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    tcdm_burst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (tcdm_r_valid_i),
        .i_dat   (tcdm_r_rdata_i),
        .i_pop   (w_pop),
        .o_dat   (data_o),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

endmodule

// File: tb/tb_tcdm_burst_reader.sv
// Bench for tcdm_burst_reader: table of bursts, hand-written corner sequences, random bursts vs. an address-arithmetic model.
module tb_tcdm_burst_reader;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base;
    logic [15:0] len;
    logic        busy, done, err, req, wen;
    logic [31:0] add, wdata, rdata, dat;
    logic [3:0]  be;
    logic        gnt, gnt_en, rvalid, opc, vld, rdy;

    always #5 clk = ~clk;
    assign gnt = req & gnt_en;

    tcdm_burst_reader #(.FIFO_DEPTH(DEPTH), .LEN_WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base), .len_i(len),
        .busy_o(busy), .done_o(done), .err_o(err),
        .tcdm_req_o(req), .tcdm_add_o(add), .tcdm_wen_o(wen), .tcdm_wdata_o(wdata), .tcdm_be_o(be),
        .tcdm_gnt_i(gnt), .tcdm_r_valid_i(rvalid), .tcdm_r_rdata_i(rdata), .tcdm_r_opc_i(opc),
        .data_o(dat), .valid_o(vld), .ready_i(rdy)
    );

    typedef struct { logic [31:0] data; logic opc; int due; } rsp_t;
    typedef struct {
        logic [31:0] base; int len; int lat; int rmode; int gmode; int opc_idx;
        logic exp_err; logic [31:0] exp_last; bit chk_lat;
    } vec_t;

    rsp_t        pend[$];
    logic [31:0] got[$];
    logic [31:0] gaddr[$];
    vec_t        vecs[5];

    int total, bad, cyc;
    int done_cnt, done_cyc, start_cyc, first_gnt, last_gnt, first_vld, last_vld, max_fly, req_cnt;
    int rmode, gmode, lat_fix, lat_rnd, opc_idx, stall_idx, stall_left;
    logic [31:0] stall_addr;
    logic        hold_prev;
    logic [31:0] hold_dat;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One clock cycle, entered and left on a falling edge: responder, sink and observation.
    task automatic tick();
        int extra;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            rvalid = 1'b1; rdata = pend[0].data; opc = pend[0].opc; pend.delete(0);
        end else begin
            rvalid = 1'b0; rdata = '0; opc = 1'b0;
        end
        case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = ($urandom_range(0, 2) != 0);
            default: rdy = 1'b0;
        endcase
        gnt_en = (gmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        if (req && stall_left > 0 && gaddr.size() == stall_idx) begin
            gnt_en = 1'b0;
            stall_left--;
            check("stall_addr_hold", add, stall_addr);
        end
        if (hold_prev) begin
            check("stream_hold_vld", vld, 1);
            check("stream_hold_dat", dat, hold_dat);
        end
        hold_prev = vld && !rdy && !rst;
        hold_dat  = dat;
        #1;
        if (req) req_cnt++;
        if (req && gnt) begin
            extra = (lat_rnd > 0) ? int'($urandom_range(0, lat_rnd)) : 0;
            pend.push_back('{data: add, opc: (gaddr.size() == opc_idx), due: cyc + 1 + lat_fix + extra});
            if (gaddr.size() == 0) first_gnt = cyc;
            last_gnt = cyc;
            gaddr.push_back(add);
        end
        if (vld && rdy) begin
            if (got.size() == 0) first_vld = cyc;
            last_vld = cyc;
            got.push_back(dat);
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (gaddr.size() - got.size() > max_fly) max_fly = gaddr.size() - got.size();
        @(negedge clk);
        cyc++;
    endtask

    task automatic launch(input logic [31:0] b, input int n);
        got.delete(); gaddr.delete();
        done_cnt = 0; done_cyc = -1; first_gnt = -1; last_gnt = -1;
        first_vld = -1; last_vld = -1; max_fly = 0; req_cnt = 0;
        base = b; len = 16'(n); start = 1'b1; start_cyc = cyc;
        tick();
        start = 1'b0; base = $urandom; len = 16'($urandom);
    endtask

    task automatic finish_burst();
        for (int i = 0; i < 2000 && done_cnt == 0; i++) tick();
        tick();
        tick();
    endtask

    // Model: word i lives at aligned base + 4*i (mod 2^32) and the responder returns its address.
    task automatic verify(input string nm, input logic [31:0] b, input int n, input logic exp_err);
        logic [31:0] a;
        check({nm, " done_pulses"}, done_cnt, 1);
        check({nm, " words"}, got.size(), n);
        check({nm, " grants"}, gaddr.size(), n);
        a = {b[31:2], 2'b00};
        for (int i = 0; i < n; i++) begin
            if (i < gaddr.size()) check($sformatf("%s addr[%0d]", nm, i), gaddr[i], a);
            if (i < got.size())   check($sformatf("%s data[%0d]", nm, i), got[i], a);
            a = a + 32'd4;
        end
        check({nm, " err"}, err, exp_err);
        check({nm, " busy_after"}, busy, 0);
        check({nm, " inflight_le_depth"}, max_fly <= DEPTH, 1);
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, " req"}, req, 0);
        check({nm, " add"}, add, 0);
        check({nm, " busy"}, busy, 0);
        check({nm, " done"}, done, 0);
        check({nm, " err"}, err, 0);
        check({nm, " valid"}, vld, 0);
    endtask

    initial begin
        logic [31:0] b;
        int n;
        rst = 1'b1; start = 1'b0; base = '0; len = '0; rdy = 1'b0; gnt_en = 1'b0;
        rvalid = 1'b0; rdata = '0; opc = 1'b0;
        rmode = 0; gmode = 0; lat_fix = 0; lat_rnd = 0; opc_idx = -1;
        stall_idx = -1; stall_left = 0; stall_addr = '0; hold_prev = 1'b0; hold_dat = '0;

        vecs[0] = '{32'h1C010000, 4,  0, 0, 0, -1, 1'b0, 32'h1C01000C, 1'b1};
        vecs[1] = '{32'hFFFFFFF8, 3,  0, 0, 0,  1, 1'b1, 32'h00000000, 1'b0};
        vecs[2] = '{32'h00001003, 5,  2, 1, 1, -1, 1'b0, 32'h00001010, 1'b0};
        vecs[3] = '{32'h80000000, 1,  0, 0, 0,  0, 1'b1, 32'h80000000, 1'b0};
        vecs[4] = '{32'h00002000, 16, 2, 1, 1, 15, 1'b1, 32'h0000203C, 1'b0};

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        check("tie_wen", wen, 1);
        check("tie_wdata", wdata, 0);
        check("tie_be", be, 4'hF);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            lat_rnd = vecs[v].lat; rmode = vecs[v].rmode; gmode = vecs[v].gmode; opc_idx = vecs[v].opc_idx;
            launch(vecs[v].base, vecs[v].len);
            finish_burst();
            verify($sformatf("vec%0d", v), vecs[v].base, vecs[v].len, vecs[v].exp_err);
            if (got.size() > 0) check($sformatf("vec%0d last", v), got[got.size()-1], vecs[v].exp_last);
            if (vecs[v].chk_lat) begin
                check("lat_first_grant", first_gnt - start_cyc, 1);
                check("lat_first_valid", first_vld - first_gnt, 2);
                check("lat_grant_rate", last_gnt - first_gnt, vecs[v].len - 1);
                check("lat_stream_rate", last_vld - first_vld, vecs[v].len - 1);
                check("lat_done_after_pop", done_cyc > last_vld, 1);
            end
        end
        lat_rnd = 0; rmode = 0; gmode = 0; opc_idx = -1;

        // Consumer stalled: credits run out after DEPTH grants.
        rmode = 2;
        launch(32'h1C010000, 8);
        repeat (19) tick();
        check("rdy_low grants", gaddr.size(), DEPTH);
        check("rdy_low req", req, 0);
        check("rdy_low popped", got.size(), 0);
        rmode = 0;
        finish_burst();
        verify("rdy_low", 32'h1C010000, 8, 1'b0);

        // Second request left ungranted for three cycles.
        stall_idx = 1; stall_left = 3; stall_addr = 32'h1C010104;
        launch(32'h1C010100, 4);
        finish_burst();
        verify("stall", 32'h1C010100, 4, 1'b0);
        check("stall consumed", stall_left, 0);
        stall_idx = -1;

        launch(32'h00000300, 0);
        finish_burst();
        verify("len0", 32'h00000300, 0, 1'b0);
        check("len0 done_delay", done_cyc - start_cyc, 2);
        check("len0 req_cycles", req_cnt, 0);

        opc_idx = 1;
        launch(32'hFFFFFFF8, 3);
        finish_burst();
        verify("wrap_err", 32'hFFFFFFF8, 3, 1'b1);
        opc_idx = -1;
        tick(); tick();
        check("err_sticky", err, 1);
        launch(32'h00000400, 1);
        check("err_cleared_by_start", err, 0);
        finish_burst();
        verify("after_err", 32'h00000400, 1, 1'b0);

        // Reset with two reads in flight.
        lat_fix = 3;
        launch(32'h00000500, 8);
        tick(); tick();
        check("pre_rst outstanding", gaddr.size() - got.size(), 2);
        check("pre_rst busy", busy, 1);
        rst = 1'b1; hold_prev = 1'b0;
        #1;
        check_idle_outputs("mid_rst");
        pend.delete(); lat_fix = 0;
        tick();
        check_idle_outputs("held_rst");
        rst = 1'b0;
        tick();
        launch(32'h00000600, 2);
        finish_burst();
        verify("post_rst", 32'h00000600, 2, 1'b0);

        rmode = 1; gmode = 1;
        for (int k = 0; k < 20; k++) begin
            b = $urandom;
            n = $urandom_range(1, 20);
            lat_rnd = $urandom_range(0, 3);
            opc_idx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            launch(b, n);
            finish_burst();
            verify($sformatf("rnd%0d", k), b, n, opc_idx >= 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
